// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - loader state encoding and memory depth shared with the CPU
package prog_loader_pkg;

   localparam int MEMORY_SIZE_DEF = 32;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN,
      S_HI,
      S_LO,
      S_WR,
      S_FILL,
      S_CHK,
      S_DONE,
      S_ERR
   } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader packing a byte stream into 16-bit words, CPU held in reset until done
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int MEMORY_SIZE = MEMORY_SIZE_DEF,
   parameter int ADDR_W      = $clog2(MEMORY_SIZE)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [7:0]        i_in_data,
   output logic              o_in_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [15:0]       o_mem_wdata,
   output logic              o_cpu_rst,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);

   localparam logic [ADDR_W:0] C_MEM_SIZE = (ADDR_W+1)'(MEMORY_SIZE);
   localparam logic [7:0]      C_MAX_LEN  = 8'(MEMORY_SIZE);

   loader_state_t     r_state;
   loader_state_t     w_next;
   loader_state_t     w_fill_or_done;
   loader_state_t     w_after_data;
   logic [ADDR_W:0]   r_n;
   logic [ADDR_W:0]   r_w;
   logic [ADDR_W:0]   w_w_inc;
   logic [7:0]        r_hi;
   logic [7:0]        r_lo;
   logic              w_accept;
   logic              w_len_bad;

   assign w_accept  = i_in_valid && o_in_ready;
   assign w_len_bad = (i_in_data == 8'd0) || (i_in_data > C_MAX_LEN);
   assign w_w_inc   = r_w + 1'b1;

   // A full image leaves nothing to zero-fill, so FILL is skipped entirely.
   assign w_fill_or_done = (r_n == C_MEM_SIZE) ? S_DONE : S_FILL;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] r_sum;

   assign w_after_data = S_CHK;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sum <= 8'd0;
      end else if (w_accept) begin
         if (r_state == S_LEN)
            r_sum <= 8'd0;
         else if (r_state == S_HI || r_state == S_LO)
            r_sum <= r_sum + i_in_data;
      end
   end
`else
   assign w_after_data = w_fill_or_done;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: if (i_start) w_next = S_LEN;
         S_LEN:  if (w_accept) w_next = w_len_bad ? S_ERR : S_HI;
         S_HI:   if (w_accept) w_next = S_LO;
         S_LO:   if (w_accept) w_next = S_WR;
         S_WR:   w_next = (w_w_inc == r_n) ? w_after_data : S_HI;
         S_FILL: if (w_w_inc == C_MEM_SIZE) w_next = S_DONE;
`ifdef LOADER_CHECKSUM_EN
         S_CHK:  if (w_accept) w_next = (i_in_data == r_sum) ? w_fill_or_done : S_ERR;
`else
         S_CHK:  w_next = S_ERR;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   // r_w is the word index during WR and the zero-fill address during FILL.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_n  <= '0;
         r_w  <= '0;
         r_hi <= 8'd0;
         r_lo <= 8'd0;
      end else begin
         case (r_state)
            S_LEN: if (w_accept) begin
               r_n <= i_in_data[ADDR_W:0];
               r_w <= '0;
            end
            S_HI:   if (w_accept) r_hi <= i_in_data;
            S_LO:   if (w_accept) r_lo <= i_in_data;
            S_WR:   r_w <= w_w_inc;
            S_FILL: r_w <= w_w_inc;
            default: ;
         endcase
      end
   end

   assign o_in_ready  = (r_state == S_LEN) || (r_state == S_HI) ||
                        (r_state == S_LO)  || (r_state == S_CHK);
   assign o_mem_we    = (r_state == S_WR) || (r_state == S_FILL);
   assign o_mem_addr  = r_w[ADDR_W-1:0];
   assign o_mem_wdata = (r_state == S_WR) ? {r_hi, r_lo} : 16'h0000;
   assign o_cpu_rst   = (r_state != S_DONE);
   assign o_busy      = (r_state == S_LEN) || (r_state == S_HI) || (r_state == S_LO) ||
                        (r_state == S_WR)  || (r_state == S_FILL) || (r_state == S_CHK);
   assign o_done      = (r_state == S_DONE);
   assign o_error     = (r_state == S_ERR);

endmodule
